// File: rtl/rca_pkg.sv
// rca_pkg
//   Shared types and helpers for the ripple-carry-adder result collector.
//   - RCA_WIDTH_DEFAULT / RCA_CNT_W_DEFAULT : default operand and tag widths
//   - rca_result_t : {cout, sum} as produced by the adder (default widths)
//   - rca_entry_t  : {seq, result} as stored in the result FIFO (default widths)
//   - sat_inc      : saturating increment used by the status counters
package rca_pkg;

  localparam int RCA_WIDTH_DEFAULT = 4;
  localparam int RCA_CNT_W_DEFAULT = 8;

  typedef struct packed {
    logic                         cout;
    logic [RCA_WIDTH_DEFAULT-1:0] sum;
  } rca_result_t;

  typedef struct packed {
    logic [RCA_CNT_W_DEFAULT-1:0] seq;
    rca_result_t                  result;
  } rca_entry_t;

  // Increment 'value' unless it already equals the all-ones pattern of a
  // 'width'-bit counter. Callers truncate the result back to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (value >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rca_sync_fifo.sv
// rca_sync_fifo
//   Synchronous first-word-fall-through FIFO, DEPTH entries of entry_t.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset (clears pointers)
//     push, wdata     : write request and data; ignored when full unless a
//                       pop is accepted in the same cycle
//     pop             : read request; ignored when empty
//     rdata           : head entry, read combinationally from storage
//     full, empty     : occupancy flags
//     level           : number of stored entries (0..DEPTH)
//   There is no empty-bypass: a push into an empty FIFO becomes visible on
//   rdata only after the write edge.
module rca_sync_fifo
  import rca_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0],
  parameter int  PTR_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] level
);

  localparam int AW = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  entry_t           mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags, level, head readout and qualified push/pop strobes.
  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    level     = wr_ptr_r - rd_ptr_r;
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    rdata     = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Storage write; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rca_result_collector.sv
// rca_result_collector
//   Downstream stage of a pipelined ripple-carry adder. A valid flag is
//   re-timed through a LATENCY-deep delay line so each {Cout, Sum} is
//   captured on the cycle it leaves the adder. Captured results are tagged
//   with a sequence number and queued in a small FWFT FIFO.
//   Ports:
//     Clock, Reset        : clock, asynchronous active-high reset
//     InValid             : operands launched into the adder this cycle
//     Sum, Cout           : adder outputs
//     OutValid, OutReady  : valid/ready handshake on the FIFO head
//     OutData, OutSeq     : head entry {Cout, Sum} and its sequence tag
//     Level               : FIFO occupancy
//     CarryCount          : arrivals with Cout=1 (saturating)
//     DropCount           : arrivals lost to a full FIFO (saturating)
module rca_result_collector
  import rca_pkg::*;
#(
  parameter int WIDTH   = RCA_WIDTH_DEFAULT,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = RCA_CNT_W_DEFAULT
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [WIDTH-1:0]         Sum,
  input  logic                     Cout,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WIDTH:0]           OutData,
  output logic [CNT_W-1:0]         OutSeq,
  output logic [$clog2(DEPTH):0]   Level,
  output logic [CNT_W-1:0]         CarryCount,
  output logic [CNT_W-1:0]         DropCount
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Same layout as rca_result_t / rca_entry_t, sized by this instance.
  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } result_t;

  typedef struct packed {
    logic [CNT_W-1:0] seq;
    result_t          result;
  } entry_t;

  logic [LATENCY-1:0] vdly_r;
  logic [CNT_W-1:0]   seq_r;
  logic [CNT_W-1:0]   carry_count_r;
  logic [CNT_W-1:0]   drop_count_r;

  logic               arr_v_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [LVL_W-1:0]   fifo_level_s;
  entry_t             wr_entry_s;
  entry_t             rd_entry_s;

  // Valid delay line: stage 0 samples InValid, the last stage marks arrival.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      vdly_r <= '0;
    end else begin
      vdly_r[0] <= InValid;
      for (int i = 1; i < LATENCY; i++) begin
        vdly_r[i] <= vdly_r[i-1];
      end
    end
  end

  // Push/drop decision. A full FIFO still accepts an arrival when the head
  // is popped on the same edge, so the slot freed by the pop is reused.
  always_comb begin
    arr_v_s           = vdly_r[LATENCY-1];
    pop_s             = !fifo_empty_s && OutReady;
    push_s            = arr_v_s && (!fifo_full_s || pop_s);
    drop_s            = arr_v_s && fifo_full_s && !pop_s;
    wr_entry_s.seq    = seq_r;
    wr_entry_s.result = '{cout: Cout, sum: Sum};
  end

  // Sequence tag and saturating status counters. The tag advances on every
  // arrival, dropped or not, so gaps in OutSeq reveal drops.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      seq_r         <= '0;
      carry_count_r <= '0;
      drop_count_r  <= '0;
    end else begin
      if (arr_v_s) begin
        seq_r <= seq_r + CNT_W'(1);
        if (Cout) begin
          carry_count_r <= CNT_W'(sat_inc(32'(carry_count_r), CNT_W));
        end
      end
      if (drop_s) begin
        drop_count_r <= CNT_W'(sat_inc(32'(drop_count_r), CNT_W));
      end
    end
  end

  rca_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .PTR_W   (LVL_W)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (rd_entry_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  // Output mapping; head data comes straight from FIFO storage.
  always_comb begin
    OutValid   = !fifo_empty_s;
    OutData    = rd_entry_s.result;
    OutSeq     = rd_entry_s.seq;
    Level      = fifo_level_s;
    CarryCount = carry_count_r;
    DropCount  = drop_count_r;
  end

endmodule

// File: tb/tb_rca_result_collector.sv
module tb_rca_result_collector;

  localparam int W    = 4;
  localparam int LAT  = 4;
  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int LW   = $clog2(D) + 1;
  localparam int CMAX = (1 << CW) - 1;
  localparam int RING = 16;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          InValid = 1'b0;
  logic [W-1:0]  Sum = '0;
  logic          Cout = 1'b0;
  logic          OutValid;
  logic          OutReady = 1'b0;
  logic [W:0]    OutData;
  logic [CW-1:0] OutSeq;
  logic [LW-1:0] Level;
  logic [CW-1:0] CarryCount;
  logic [CW-1:0] DropCount;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // adder model: results scheduled to appear on Sum/Cout LAT cycles after launch
  bit       sched_v   [RING];
  int       sched_res [RING];

  // reference model of the collector
  int q_data[$];
  int q_seq[$];
  int m_seq   = 0;
  int m_carry = 0;
  int m_drop  = 0;

  always #5 Clock = ~Clock;

  rca_result_collector #(
    .WIDTH(W), .LATENCY(LAT), .DEPTH(D), .CNT_W(CW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .Sum(Sum), .Cout(Cout),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutSeq(OutSeq),
    .Level(Level), .CarryCount(CarryCount), .DropCount(DropCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(OutValid), 32'(q_data.size() != 0));
    chk("level", 32'(Level), 32'(q_data.size()));
    chk("carry", 32'(CarryCount), 32'(m_carry));
    chk("drop", 32'(DropCount), 32'(m_drop));
    if (q_data.size() != 0) begin
      chk("data", 32'(OutData), 32'(q_data[0]));
      chk("seq", 32'(OutSeq), 32'(q_seq[0]));
    end
  endtask

  // one clock cycle: drive inputs, advance the model, then check after the edge
  task automatic step(input bit iv, input int a, input int b, input int cin, input bit rdy);
    int  slot;
    bit  arr;
    int  res;
    bit  pop_now;
    bit  full_now;
    slot = cyc % RING;
    arr  = sched_v[slot];
    res  = sched_res[slot];
    sched_v[slot] = 1'b0;
    InValid  = iv;
    OutReady = rdy;
    if (arr) begin
      Sum  = W'(res);
      Cout = 1'(res >> W);
    end else begin
      Sum  = W'($urandom);
      Cout = 1'($urandom);
    end
    if (iv) begin
      sched_v[(cyc + LAT) % RING]   = 1'b1;
      sched_res[(cyc + LAT) % RING] = (a + b + cin) & 32'h1F;
    end
    pop_now  = (q_data.size() != 0) && rdy;
    full_now = (q_data.size() == D);
    if (pop_now) begin
      void'(q_data.pop_front());
      void'(q_seq.pop_front());
    end
    if (arr) begin
      if (!full_now || pop_now) begin
        q_data.push_back(res);
        q_seq.push_back(m_seq);
      end else if (m_drop < CMAX) begin
        m_drop++;
      end
      if (((res >> W) & 1) == 1 && m_carry < CMAX) m_carry++;
      m_seq = (m_seq + 1) % (CMAX + 1);
    end
    @(posedge Clock);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, rdy);
  endtask

  // reset asserted between edges; status must clear without a clock edge
  task automatic do_reset();
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    #1;
    chk("rst_valid", 32'(OutValid), 32'd0);
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_carry", 32'(CarryCount), 32'd0);
    chk("rst_drop", 32'(DropCount), 32'd0);
    q_data.delete();
    q_seq.delete();
    m_seq = 0; m_carry = 0; m_drop = 0;
    for (int i = 0; i < RING; i++) sched_v[i] = 1'b0;
    @(posedge Clock);
    #1;
    cyc++;
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < RING; i++) begin
      sched_v[i] = 1'b0;
      sched_res[i] = 0;
    end
    @(posedge Clock);
    #1;
    do_reset();
    idle(3, 1'b0);

    // in-order stream, consumer always ready
    step(1'b1, 3, 4, 0, 1'b1);
    step(1'b1, 5, 7, 0, 1'b1);
    step(1'b1, 1, 9, 0, 1'b1);
    step(1'b1, 11, 2, 0, 1'b1);
    step(1'b1, 7, 6, 0, 1'b1);
    step(1'b1, 15, 0, 1, 1'b1);
    idle(LAT + 3, 1'b1);

    // backpressure: 6 results into a 4-deep FIFO, then drain
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, i, 2 * i, 0, 1'b0);
    idle(LAT + 2, 1'b0);
    idle(D + 2, 1'b1);
    step(1'b1, 9, 9, 0, 1'b1);
    idle(LAT + 2, 1'b1);

    // full FIFO with a pop on the same edge as an arrival
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, i, 1, 0, 1'b0);
    idle(LAT, 1'b0);
    step(1'b1, 14, 3, 0, 1'b0);
    idle(LAT - 1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1);
    idle(D + 2, 1'b1);

    // reset with results both in the FIFO and in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, i, 5, 1, 1'b0);
    idle(LAT, 1'b0);
    step(1'b1, 2, 2, 0, 1'b0);
    step(1'b1, 3, 3, 0, 1'b0);
    do_reset();
    idle(LAT + 2, 1'b1);
    step(1'b1, 8, 8, 0, 1'b1);
    idle(LAT + 2, 1'b1);

    // saturation of CarryCount and wrap of the sequence tag
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 15, 15, 1, 1'b1);
    idle(LAT + 3, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 2) != 0);
    end
    idle(LAT + D + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
